// File: rtl/bcd_serial_addsub_if.sv
// Request/response bundle for the digit-serial BCD add/subtract unit.
// The requester drives start/mode/operands; the unit returns status and result.
interface bcd_serial_addsub_if #(
  parameter int NDIGITS = 4
);
  logic                   start;
  logic                   mode;
  logic [4*NDIGITS-1:0]   bcd_a;
  logic [4*NDIGITS-1:0]   bcd_b;
  logic                   busy;
  logic                   done;
  logic [4*NDIGITS+3:0]   bcd_out;
  logic                   neg;
  logic                   err;

  modport master (
    output start, mode, bcd_a, bcd_b,
    input  busy, done, bcd_out, neg, err
  );

  modport slave (
    input  start, mode, bcd_a, bcd_b,
    output busy, done, bcd_out, neg, err
  );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD add/subtract, LSD first. Subtraction goes through nine's
// complement; a negative result is turned into its magnitude by a second FIX pass.

// One decimal-correct digit step: sum = x + y + cin, wrapped into 0..9 with carry.
module bcd_digit_step (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] raw;

  always_comb begin
    raw  = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    cout = (raw > 5'd9);
    sum  = cout ? (raw[3:0] + 4'd6) : raw[3:0];
  end
endmodule

module bcd_serial_addsub #(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_serial_addsub_if.slave   bus
);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int W  = 4 * NDIGITS;

  typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} stateT;

  stateT          state, stateNxt;
  logic           modeR, modeNxt;
  logic [W-1:0]   aR, aNxt;
  logic [W-1:0]   bR, bNxt;
  logic [IW-1:0]  idx, idxNxt;
  logic           carry, carryNxt;
  logic [W+3:0]   outR, outNxt;
  logic           negR, negNxt;
  logic           errR, errNxt;

  logic [3:0]     aDig, bDig, dDig;
  logic [3:0]     stepX, stepY, stepSum;
  logic           stepCout;
  logic           badIn;
  logic           lastIdx;

  // Current digit of each operand and of the partial result.
  always_comb begin
    aDig = 4'd0;
    bDig = 4'd0;
    dDig = 4'd0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx == IW'(i)) begin
        aDig = aR[4*i +: 4];
        bDig = bR[4*i +: 4];
        dDig = outR[4*i +: 4];
      end
    end
  end

  always_comb begin
    badIn = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bus.bcd_a[4*i +: 4] > 4'd9 || bus.bcd_b[4*i +: 4] > 4'd9)
        badIn = 1'b1;
    end
  end

  // ADD: A + B (or A + nine's complement of B). FIX: nine's complement of the
  // partial result plus the pending carry, i.e. ten's complement serially.
  always_comb begin
    if (state == FIX) begin
      stepX = 4'd9 - dDig;
      stepY = 4'd0;
    end else begin
      stepX = aDig;
      stepY = modeR ? (4'd9 - bDig) : bDig;
    end
  end

  bcd_digit_step uStep (
    .x    (stepX),
    .y    (stepY),
    .cin  (carry),
    .sum  (stepSum),
    .cout (stepCout)
  );

  assign lastIdx = (idx == IW'(NDIGITS - 1));

  always_comb begin
    stateNxt = state;
    modeNxt  = modeR;
    aNxt     = aR;
    bNxt     = bR;
    idxNxt   = idx;
    carryNxt = carry;
    outNxt   = outR;
    negNxt   = negR;
    errNxt   = errR;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          modeNxt  = bus.mode;
          aNxt     = bus.bcd_a;
          bNxt     = bus.bcd_b;
          idxNxt   = '0;
          outNxt   = '0;
          negNxt   = 1'b0;
          errNxt   = 1'b0;
          carryNxt = bus.mode;
          if (badIn) begin
            errNxt   = 1'b1;
            stateNxt = DONE;
          end else begin
            stateNxt = ADD;
          end
        end else if (state == DONE) begin
          stateNxt = IDLE;
        end
      end

      ADD: begin
        for (int i = 0; i < NDIGITS; i++)
          if (idx == IW'(i)) outNxt[4*i +: 4] = stepSum;
        carryNxt = stepCout;
        idxNxt   = idx + IW'(1);
        if (lastIdx) begin
          idxNxt = '0;
          if (!modeR) begin
            outNxt[W +: 4] = {3'b000, stepCout};
            stateNxt       = DONE;
          end else if (stepCout) begin
            stateNxt = DONE;
          end else begin
            // No end-around borrow out: A < B, result is in ten's complement.
            carryNxt = 1'b1;
            stateNxt = FIX;
          end
        end
      end

      FIX: begin
        for (int i = 0; i < NDIGITS; i++)
          if (idx == IW'(i)) outNxt[4*i +: 4] = stepSum;
        carryNxt = stepCout;
        idxNxt   = idx + IW'(1);
        if (lastIdx) begin
          idxNxt   = '0;
          negNxt   = 1'b1;
          stateNxt = DONE;
        end
      end

      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      modeR <= 1'b0;
      aR    <= '0;
      bR    <= '0;
      idx   <= '0;
      carry <= 1'b0;
      outR  <= '0;
      negR  <= 1'b0;
      errR  <= 1'b0;
    end else begin
      state <= stateNxt;
      modeR <= modeNxt;
      aR    <= aNxt;
      bR    <= bNxt;
      idx   <= idxNxt;
      carry <= carryNxt;
      outR  <= outNxt;
      negR  <= negNxt;
      errR  <= errNxt;
    end
  end

  assign bus.busy    = (state == ADD) || (state == FIX);
  assign bus.done    = (state == DONE);
  assign bus.bcd_out = outR;
  assign bus.neg     = negR;
  assign bus.err     = errR;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub: NDIGITS=2 and NDIGITS=4 instances,
// hand-computed results, latencies and busy lengths.
module tb_bcd_serial_addsub;
  logic clk = 1'b0;
  logic rst2, rst4;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_serial_addsub_if #(.NDIGITS(2)) if2 ();
  bcd_serial_addsub_if #(.NDIGITS(4)) if4 ();

  bcd_serial_addsub #(.NDIGITS(2)) dut2 (.clk(clk), .reset(rst2), .bus(if2.slave));
  bcd_serial_addsub #(.NDIGITS(4)) dut4 (.clk(clk), .reset(rst4), .bus(if4.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one request on a negedge, then count negedges until done (bounded).
  task automatic op2(input logic m, input logic [7:0] a, input logic [7:0] b,
                     output int lat, output int bz);
    @(negedge clk);
    if2.start = 1'b1; if2.mode = m; if2.bcd_a = a; if2.bcd_b = b;
    lat = 0; bz = 0;
    do begin
      @(negedge clk);
      if2.start = 1'b0;
      lat++;
      if (if2.busy) bz++;
    end while (!if2.done && lat < 30);
  endtask

  // skipEdge: caller is already on the negedge where start should be driven.
  task automatic op4(input bit skipEdge, input logic m, input logic [15:0] a,
                     input logic [15:0] b, output int lat);
    if (!skipEdge) @(negedge clk);
    if4.start = 1'b1; if4.mode = m; if4.bcd_a = a; if4.bcd_b = b;
    lat = 0;
    do begin
      @(negedge clk);
      if4.start = 1'b0;
      lat++;
    end while (!if4.done && lat < 30);
  endtask

  initial begin
    int lat, bz;
    if2.start = 1'b0; if2.mode = 1'b0; if2.bcd_a = '0; if2.bcd_b = '0;
    if4.start = 1'b0; if4.mode = 1'b0; if4.bcd_a = '0; if4.bcd_b = '0;
    rst2 = 1'b1; rst4 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(if2.busy), 64'd0);
    chk("rst_done", 64'(if2.done), 64'd0);
    chk("rst_out",  64'(if2.bcd_out), 64'h0);
    chk("rst_flags", 64'({if2.neg, if2.err}), 64'd0);
    rst2 = 1'b0; rst4 = 1'b0;

    op2(1'b0, 8'h11, 8'h11, lat, bz);
    chk("add11_lat", 64'(lat), 64'd3);
    chk("add11_out", 64'(if2.bcd_out), 64'h022);
    chk("add11_flags", 64'({if2.neg, if2.err}), 64'd0);
    @(negedge clk);
    chk("add11_done_1cyc", 64'(if2.done), 64'd0);

    op2(1'b0, 8'h22, 8'h22, lat, bz);
    chk("add22_out", 64'(if2.bcd_out), 64'h044);
    op2(1'b0, 8'h44, 8'h44, lat, bz);
    chk("add44_lat", 64'(lat), 64'd3);
    chk("add44_out", 64'(if2.bcd_out), 64'h088);

    op2(1'b0, 8'h99, 8'h99, lat, bz);
    chk("add99_out", 64'(if2.bcd_out), 64'h198);
    chk("add99_busy", 64'(bz), 64'd2);

    op2(1'b1, 8'h42, 8'h17, lat, bz);
    chk("sub42_17_lat", 64'(lat), 64'd3);
    chk("sub42_17_out", 64'(if2.bcd_out), 64'h025);
    chk("sub42_17_neg", 64'(if2.neg), 64'd0);

    op2(1'b1, 8'h17, 8'h42, lat, bz);
    chk("sub17_42_lat", 64'(lat), 64'd5);
    chk("sub17_42_out", 64'(if2.bcd_out), 64'h025);
    chk("sub17_42_neg", 64'(if2.neg), 64'd1);
    chk("sub17_42_busy", 64'(bz), 64'd4);

    op2(1'b1, 8'h55, 8'h55, lat, bz);
    chk("sub55_out", 64'(if2.bcd_out), 64'h000);
    chk("sub55_neg", 64'(if2.neg), 64'd0);

    // Non-BCD digit in A: immediate done with err, result cleared.
    op2(1'b0, 8'h12, 8'h30, lat, bz);
    op2(1'b0, 8'h1A, 8'h05, lat, bz);
    chk("err_lat", 64'(lat), 64'd1);
    chk("err_flag", 64'(if2.err), 64'd1);
    chk("err_out", 64'(if2.bcd_out), 64'h000);
    op2(1'b0, 8'h11, 8'h11, lat, bz);
    chk("err_clear", 64'(if2.err), 64'd0);
    chk("err_clear_out", 64'(if2.bcd_out), 64'h022);

    // Start while busy must be ignored; then reset mid-ADD.
    @(negedge clk);
    if2.start = 1'b1; if2.mode = 1'b0; if2.bcd_a = 8'h34; if2.bcd_b = 8'h21;
    @(negedge clk);
    if2.bcd_a = 8'h77; if2.bcd_b = 8'h11; if2.mode = 1'b1;
    @(negedge clk);
    if2.start = 1'b0;
    chk("ign_busy", 64'(if2.busy), 64'd1);
    chk("ign_digit0", 64'(if2.bcd_out[3:0]), 64'h5);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    chk("midrst_busy", 64'(if2.busy), 64'd0);
    chk("midrst_out", 64'(if2.bcd_out), 64'h000);
    bz = 0;
    repeat (5) begin
      @(negedge clk);
      if (if2.done) bz++;
    end
    chk("midrst_no_done", 64'(bz), 64'd0);

    // NDIGITS=4 back-to-back: second start issued in the DONE cycle.
    op4(1'b0, 1'b0, 16'h9999, 16'h0001, lat);
    chk("b2b_add_lat", 64'(lat), 64'd5);
    chk("b2b_add_out", 64'(if4.bcd_out), 64'h10000);
    op4(1'b1, 1'b1, 16'h0000, 16'h0001, lat);
    chk("b2b_sub_lat", 64'(lat), 64'd9);
    chk("b2b_sub_out", 64'(if4.bcd_out), 64'h00001);
    chk("b2b_sub_neg", 64'(if4.neg), 64'd1);
    @(negedge clk);
    chk("b2b_done_1cyc", 64'(if4.done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
